prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 22 ++
 rtl/word_assembler.sv | 55 +++++
 rtl/prog_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
//
// Contents:
//   LEN_W          - width of the word-count header field (16)
//   BYTES_PER_WORD - payload bytes per instruction word (4)
//   state_t        - loader state machine encoding
package loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs payload bytes LSB-first into 32-bit words
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - restart packing at byte lane 0 (new session)
//   byte_en     - a payload byte is accepted this cycle
//   byte_data   - the payload byte
//   last_lane   - the next accepted byte completes a word
//   word_valid  - one-cycle pulse, the cycle after the completing byte
//   word_data   - assembled word, held until the next word completes
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] lane;
    logic [31:0]       shreg;

    assign last_lane = (lane == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane       <= '0;
            shreg      <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= '0;
            end else if (byte_en) begin
                // Newest byte enters at the top so the first byte ends up in [7:0].
                shreg <= {byte_data, shreg[31:8]};
                if (last_lane) begin
                    lane       <= '0;
                    word_valid <= 1'b1;
                    word_data  <= {byte_data, shreg[31:8]};
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader into instruction memory
//
// Stream: LEN_LO, LEN_HI (word count N), 4*N payload bytes (little-endian
// words), one checksum byte (XOR of the payload bytes).
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start       - one-cycle pulse that opens a load session
//   rx_data     - incoming stream byte
//   rx_valid    - rx_data valid; transfer when rx_valid && rx_ready
//   rx_ready    - loader accepting bytes
//   imem_we     - instruction-memory write strobe (one cycle per word)
//   imem_addr   - word address of the write
//   imem_wdata  - word to write
//   core_hold   - keeps the core in reset until a load completes
//   done        - load finished successfully
//   error       - load aborted (oversize length or bad checksum)
//
// Build option: define LOADER_CHECKSUM_EN to compare the checksum byte;
// without it the checksum byte is consumed and ignored.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam int               MAX_WORDS   = 2 ** ADDR_W;
    localparam logic [LEN_W:0]   MAX_WORDS_L = (LEN_W + 1)'(MAX_WORDS);

    state_t             state;
    state_t             next_state;
    logic               xfer;
    logic               start_session;
    logic               data_xfer;
    logic               last_lane;
    logic               last_word;
    logic               csum_ok;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_n;
    logic [LEN_W-1:0]   word_cnt;

    assign xfer          = rx_valid && rx_ready;
    assign start_session = start && (state == IDLE || state == DONE || state == ERR);
    assign data_xfer     = xfer && (state == DATA);
    assign len_n         = {rx_data, len_lo};
    // Only evaluated in DATA, where len >= 1.
    assign last_word     = (word_cnt == len - LEN_W'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) next_state = LEN0;
            end
            LEN0: begin
                if (xfer) next_state = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_n} > MAX_WORDS_L) next_state = ERR;
                    else if (len_n == '0)            next_state = CSUM;
                    else                             next_state = DATA;
                end
            end
            DATA: begin
                if (xfer && last_lane && last_word) next_state = CSUM;
            end
            CSUM: begin
                if (xfer) next_state = csum_ok ? DONE : ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rx_ready  = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            LEN0, LEN1, DATA, CSUM: rx_ready = 1'b1;
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Length capture and word addressing. The address is latched as the word
    // completes so it lines up with the assembler's delayed word_valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            imem_addr <= '0;
        end else if (start_session) begin
            word_cnt <= '0;
        end else begin
            if (state == LEN0 && xfer) len_lo <= rx_data;
            if (state == LEN1 && xfer) len    <= len_n;
            if (data_xfer && last_lane) begin
                imem_addr <= word_cnt[ADDR_W-1:0];
                word_cnt  <= word_cnt + LEN_W'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start_session) begin
            csum <= '0;
        end else if (data_xfer) begin
            csum <= csum ^ rx_data;
        end
    end

    assign csum_ok = (rx_data == csum);
`else
    assign csum_ok = 1'b1;
`endif

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_session),
        .byte_en    (data_xfer),
        .byte_data  (rx_data),
        .last_lane  (last_lane),
        .word_valid (imem_we),
        .word_data  (imem_wdata)
    );

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_wr;
    logic [31:0] pay[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe cycle must match the next expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                exp_wr = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(exp_wr.addr));
                check("wr_data", imem_wdata, exp_wr.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_end(input bit ok);
        tick();
        check("done", 32'(done), 32'(ok));
        check("error", 32'(error), 32'(!ok));
        check("core_hold", 32'(core_hold), 32'(!ok));
        check("rx_ready_end", 32'(rx_ready), 32'd0);
        check("pending_writes", exp_q.size(), 32'd0);
    endtask

    // cs_mode: 0 = correct checksum, 1 = inverted, 2 = cs_byte as given.
    task automatic run_load(input int n, input int gap, input int cs_mode,
                            input logic [7:0] cs_byte, input bit poke_start);
        logic [7:0]  cs;
        logic [7:0]  sent;
        logic [15:0] n16;
        logic [31:0] word;
        wr_t         e;
        cs  = 8'h00;
        n16 = 16'(n);
        pulse_start();
        check("rx_ready_len0", 32'(rx_ready), 32'd1);
        send_byte(n16[7:0], gap);
        send_byte(n16[15:8], gap);
        for (int w = 0; w < n; w++) begin
            word   = pay[w];
            e.addr = ADDR_W'(w);
            e.data = word;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ word[8*k +: 8];
                send_byte(word[8*k +: 8], gap);
                if (poke_start && w == 0 && k == 0) pulse_start();
            end
        end
        sent = (cs_mode == 0) ? cs : (cs_mode == 1) ? ~cs : cs_byte;
        send_byte(sent, gap);
        check_end(!CSUM_EN || (sent == cs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single word, checksum byte 6F as in the reference stream.
        pay = {32'h0000_0013};
        run_load(1, 0, 2, 8'h6F, 1'b0);

        // Same word with a matching checksum.
        run_load(1, 0, 0, 8'h00, 1'b0);

        // Two words, rx_valid toggling, stray start mid-DATA.
        pay = {32'hDEAD_BEEF, 32'h0000_0093};
        run_load(2, 1, 0, 8'h00, 1'b1);

        // Empty program.
        pay.delete();
        run_load(0, 0, 0, 8'h00, 1'b0);

        // Oversize header N = 0x0101.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("big_error", 32'(error), 32'd1);
        check("big_rx_ready", 32'(rx_ready), 32'd0);
        check("big_done", 32'(done), 32'd0);
        check("big_core_hold", 32'(core_hold), 32'd1);
        tick();
        check("big_no_writes", exp_q.size(), 32'd0);

        // Bad checksum, then a restart.
        pay = {32'h0102_0304, 32'hA5A5_5A5A, 32'hFFFF_0000};
        run_load(3, 0, 1, 8'h00, 1'b0);
        pay = {32'h1357_9BDF};
        run_load(1, 0, 0, 8'h00, 1'b0);

        // Full capacity: last address 255, no wrap.
        pay.delete();
        for (int i = 0; i < 256; i++) pay.push_back($urandom);
        run_load(256, 0, 0, 8'h00, 1'b0);

        // Reset mid-DATA after two payload bytes.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_imem_we", 32'(imem_we), 32'd0);
        check("mid_rst_imem_wdata", imem_wdata, 32'd0);
        check("mid_rst_core_hold", 32'(core_hold), 32'd1);
        tick();
        tick();
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_rx_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        tick();
        check("post_rst_no_writes", exp_q.size(), 32'd0);
        pay = {32'h1234_5678};
        run_load(1, 0, 0, 8'h00, 1'b0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
